// File: rtl/boid_pkg.sv
// Shared definitions for the boid memory sequencer.
//   FIX_FRAC  : number of fractional bits in the signed 16.16 fixed-point format
//   fix16_t   : signed 32-bit 16.16 value as stored in boid memory
//   WB_*      : bit positions inside the 7-bit memory write-enable bus
//   state_e   : sequencer FSM states
//   clamp_sym : saturate a 33-bit signed sum into [-lim, +lim]
package boid_pkg;

    localparam int FIX_FRAC = 16;

    typedef logic signed [31:0] fix16_t;

    localparam int WB_GLOBAL = 0;
    localparam int WB_X      = 1;
    localparam int WB_Y      = 2;
    localparam int WB_VX     = 3;
    localparam int WB_VY     = 4;
    localparam int WB_VXACC  = 5;
    localparam int WB_VYACC  = 6;

    localparam logic [6:0] WB_ALL  = 7'h7F;
    localparam logic [6:0] WB_NONE = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_VEL  = 3'd2,
        ST_POS  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Symmetric saturation; lim is positive and small enough that the
    // result always fits back into 32 bits.
    function automatic fix16_t clamp_sym(input logic signed [32:0] val,
                                         input logic signed [32:0] lim);
        logic signed [32:0] res;
        if (val > lim) begin
            res = lim;
        end else if (val < -lim) begin
            res = -lim;
        end else begin
            res = val;
        end
        return res[31:0];
    endfunction

endpackage

// File: rtl/boid_axis_update.sv
// One-axis kinematic update for a boid, purely combinational.
//   p_i, v_i, acc_i : current position, velocity and acceleration (16.16)
//   v_clamp_o       : v_i + acc_i saturated to +/-(VMAX<<16)
//   p_o, v_o        : p_i + v_clamp_o with edge bounce applied; v_o is the
//                     clamped velocity, negated when a bounce happened
// Parameters: MAX is the screen extent of this axis (valid positions are
// 0..MAX-1 whole pixels), VMAX the per-component speed limit in pixels/frame.
module boid_axis_update
    import boid_pkg::*;
#(
    parameter int MAX  = 640,
    parameter int VMAX = 6
) (
    input  fix16_t p_i,
    input  fix16_t v_i,
    input  fix16_t acc_i,
    output fix16_t v_clamp_o,
    output fix16_t p_o,
    output fix16_t v_o
);

    localparam logic signed [32:0] V_LIM = 33'(VMAX * (2 ** FIX_FRAC));
    localparam logic signed [32:0] P_MAX = 33'((MAX - 1) * (2 ** FIX_FRAC));

    logic signed [32:0] v_sum_s;
    logic signed [32:0] p_sum_s;
    fix16_t             v_c_s;

    // Saturating velocity integration followed by position integration and bounce.
    always_comb begin
        v_sum_s   = $signed({v_i[31], v_i}) + $signed({acc_i[31], acc_i});
        v_c_s     = clamp_sym(v_sum_s, V_LIM);
        v_clamp_o = v_c_s;
        p_sum_s   = $signed({p_i[31], p_i}) + $signed({v_c_s[31], v_c_s});
        // Landing exactly on 0 or on the last pixel is legal and does not bounce.
        if (p_sum_s < 33'sd0) begin
            p_o = 32'sd0;
            v_o = -v_c_s;
        end else if (p_sum_s > P_MAX) begin
            p_o = P_MAX[31:0];
            v_o = -v_c_s;
        end else begin
            p_o = p_sum_s[31:0];
            v_o = v_c_s;
        end
    end

endmodule

// File: rtl/boid_mem_sequencer.sv
// Per-frame boid state updater: walks boids 0..num_boids-1 through
// RD -> VEL -> POS -> WR, writing integrated position/velocity back and
// clearing the acceleration accumulators.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : one-cycle request to run a pass (IDLE only)
//   busy, done            : pass in progress / one-cycle completion pulse
//   which_boid, wb_en     : memory boid select and write enables
//   *_out_32, v*_acc_out  : memory read data (combinational on which_boid)
//   *_in_32, v*_acc_in    : memory write data (accumulators always 0)
module boid_mem_sequencer
    import boid_pkg::*;
#(
    parameter int num_boids = 2,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int VMAX      = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(num_boids):0]     which_boid,
    output logic [6:0]                     wb_en,
    input  logic [31:0]                    x_out_32,
    input  logic [31:0]                    y_out_32,
    input  logic [31:0]                    vx_out_32,
    input  logic [31:0]                    vy_out_32,
    input  logic [31:0]                    vx_acc_out,
    input  logic [31:0]                    vy_acc_out,
    output logic [31:0]                    x_in_32,
    output logic [31:0]                    y_in_32,
    output logic [31:0]                    vx_in_32,
    output logic [31:0]                    vy_in_32,
    output logic [31:0]                    vx_acc_in,
    output logic [31:0]                    vy_acc_in
);

    localparam int                IDX_W    = $clog2(num_boids) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(num_boids - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [6:0]         wb_en_q, wb_en_d;
    fix16_t             x_q, x_d, y_q, y_d;
    fix16_t             vx_q, vx_d, vy_q, vy_d;
    fix16_t             ax_q, ax_d, ay_q, ay_d;
    fix16_t             x_wr_q, x_wr_d, y_wr_q, y_wr_d;
    fix16_t             vx_wr_q, vx_wr_d, vy_wr_q, vy_wr_d;

    fix16_t             x_vc_s, x_p_s, x_v_s;
    fix16_t             y_vc_s, y_p_s, y_v_s;

    // In POS the stored velocity is already clamped and the stored
    // acceleration already cleared, so the same datapath yields p + v'.
    boid_axis_update #(.MAX(X_MAX), .VMAX(VMAX)) u_axis_x (
        .p_i       (x_q),
        .v_i       (vx_q),
        .acc_i     (ax_q),
        .v_clamp_o (x_vc_s),
        .p_o       (x_p_s),
        .v_o       (x_v_s)
    );

    boid_axis_update #(.MAX(Y_MAX), .VMAX(VMAX)) u_axis_y (
        .p_i       (y_q),
        .v_i       (vy_q),
        .acc_i     (ay_q),
        .v_clamp_o (y_vc_s),
        .p_o       (y_p_s),
        .v_o       (y_v_s)
    );

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wb_en_d = WB_NONE;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        x_wr_d  = 32'sd0;
        y_wr_d  = 32'sd0;
        vx_wr_d = 32'sd0;
        vy_wr_d = 32'sd0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                x_d     = fix16_t'(x_out_32);
                y_d     = fix16_t'(y_out_32);
                vx_d    = fix16_t'(vx_out_32);
                vy_d    = fix16_t'(vy_out_32);
                ax_d    = fix16_t'(vx_acc_out);
                ay_d    = fix16_t'(vy_acc_out);
                state_d = ST_VEL;
            end
            ST_VEL: begin
                vx_d    = x_vc_s;
                vy_d    = y_vc_s;
                ax_d    = 32'sd0;
                ay_d    = 32'sd0;
                state_d = ST_POS;
            end
            ST_POS: begin
                x_d     = x_p_s;
                y_d     = y_p_s;
                vx_d    = x_v_s;
                vy_d    = y_v_s;
                x_wr_d  = x_p_s;
                y_wr_d  = y_p_s;
                vx_wr_d = x_v_s;
                vy_wr_d = y_v_s;
                wb_en_d = WB_ALL;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts a pass and kills wb_en at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wb_en_q <= WB_NONE;
            x_q     <= 32'sd0;
            y_q     <= 32'sd0;
            vx_q    <= 32'sd0;
            vy_q    <= 32'sd0;
            ax_q    <= 32'sd0;
            ay_q    <= 32'sd0;
            x_wr_q  <= 32'sd0;
            y_wr_q  <= 32'sd0;
            vx_wr_q <= 32'sd0;
            vy_wr_q <= 32'sd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wb_en_q <= wb_en_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            x_wr_q  <= x_wr_d;
            y_wr_q  <= y_wr_d;
            vx_wr_q <= vx_wr_d;
            vy_wr_q <= vy_wr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign which_boid = idx_q;
    assign wb_en      = wb_en_q;
    assign x_in_32    = x_wr_q;
    assign y_in_32    = y_wr_q;
    assign vx_in_32   = vx_wr_q;
    assign vy_in_32   = vy_wr_q;
    assign vx_acc_in  = 32'd0;
    assign vy_acc_in  = 32'd0;

endmodule

// File: tb/tb_boid_mem_sequencer.sv
// Directed self-checking bench for boid_mem_sequencer with a two-entry
// behavioural boid memory (combinational read, write at clock edge).
module tb_boid_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [1:0]  which_boid;
    logic [6:0]  wb_en;
    logic [31:0] x_out_32, y_out_32, vx_out_32, vy_out_32, vx_acc_out, vy_acc_out;
    logic [31:0] x_in_32, y_in_32, vx_in_32, vy_in_32, vx_acc_in, vy_acc_in;

    logic [31:0] mem_x [0:1];
    logic [31:0] mem_y [0:1];
    logic [31:0] mem_vx [0:1];
    logic [31:0] mem_vy [0:1];
    logic [31:0] mem_ax [0:1];
    logic [31:0] mem_ay [0:1];

    logic        ld_en = 1'b0;
    logic        ld_idx = 1'b0;
    logic [31:0] ld_x, ld_y, ld_vx, ld_vy, ld_ax, ld_ay;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [6:0]  rec_wb [0:39];
    logic [1:0]  rec_wbi [0:39];
    logic        rec_busy [0:39];
    logic [31:0] rec_xin [0:39];
    logic [31:0] rec_axin [0:39];

    boid_mem_sequencer #(.num_boids(2), .X_MAX(640), .Y_MAX(480), .VMAX(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .which_boid (which_boid),
        .wb_en      (wb_en),
        .x_out_32   (x_out_32),
        .y_out_32   (y_out_32),
        .vx_out_32  (vx_out_32),
        .vy_out_32  (vy_out_32),
        .vx_acc_out (vx_acc_out),
        .vy_acc_out (vy_acc_out),
        .x_in_32    (x_in_32),
        .y_in_32    (y_in_32),
        .vx_in_32   (vx_in_32),
        .vy_in_32   (vy_in_32),
        .vx_acc_in  (vx_acc_in),
        .vy_acc_in  (vy_acc_in)
    );

    always #5 clk = ~clk;

    assign x_out_32   = (which_boid < 2'd2) ? mem_x[which_boid[0]]  : 32'd0;
    assign y_out_32   = (which_boid < 2'd2) ? mem_y[which_boid[0]]  : 32'd0;
    assign vx_out_32  = (which_boid < 2'd2) ? mem_vx[which_boid[0]] : 32'd0;
    assign vy_out_32  = (which_boid < 2'd2) ? mem_vy[which_boid[0]] : 32'd0;
    assign vx_acc_out = (which_boid < 2'd2) ? mem_ax[which_boid[0]] : 32'd0;
    assign vy_acc_out = (which_boid < 2'd2) ? mem_ay[which_boid[0]] : 32'd0;

    // Memory write port: bench preload or DUT write.
    always @(posedge clk) begin
        if (ld_en) begin
            mem_x[ld_idx]  <= ld_x;
            mem_y[ld_idx]  <= ld_y;
            mem_vx[ld_idx] <= ld_vx;
            mem_vy[ld_idx] <= ld_vy;
            mem_ax[ld_idx] <= ld_ax;
            mem_ay[ld_idx] <= ld_ay;
        end else if (wb_en[0] && which_boid < 2'd2) begin
            if (wb_en[1]) mem_x[which_boid[0]]  <= x_in_32;
            if (wb_en[2]) mem_y[which_boid[0]]  <= y_in_32;
            if (wb_en[3]) mem_vx[which_boid[0]] <= vx_in_32;
            if (wb_en[4]) mem_vy[which_boid[0]] <= vy_in_32;
            if (wb_en[5]) mem_ax[which_boid[0]] <= vx_acc_in;
            if (wb_en[6]) mem_ay[which_boid[0]] <= vy_acc_in;
        end
    end

    // Count completed passes.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] fx(input int v);
        return 32'(v * 65536);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_boid(input logic idx, input int x, input int y, input int vx,
                             input int vy, input int ax, input int ay);
        ld_idx = idx; ld_x = fx(x); ld_y = fx(y); ld_vx = fx(vx);
        ld_vy = fx(vy); ld_ax = fx(ax); ld_ay = fx(ay); ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Issue start and record per-cycle outputs; k=0 is sampled just after the accepting edge.
    task automatic run_pass(input bit poke, input int stop_at, output int done_k);
        done_k = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rec_wb[k] = wb_en; rec_wbi[k] = which_boid; rec_busy[k] = busy;
            rec_xin[k] = x_in_32; rec_axin[k] = vx_acc_in;
            if (done) begin
                done_k = k;
                break;
            end
            if (k == stop_at) break;
            start = (poke && k == 1) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int dk;
        int cnt0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_which", {30'd0, which_boid}, 32'd0);
        check("rst_wb_en", {25'd0, wb_en}, 32'd0);
        check("rst_x_in", x_in_32, 32'd0);
        check("rst_vx_in", vx_in_32, 32'd0);
        reset = 1'b0;

        // Pass 1: plain integration, right bounce, exact bottom edge, mid-pass start ignored
        load_boid(1'b0, 120, 100, 5, 0, 0, 0);
        load_boid(1'b1, 637, 475, 5, 4, 0, 0);
        cnt0 = done_cnt;
        run_pass(1'b1, 99, dk);
        check("p1_done_latency", 32'(dk), 32'd8);
        for (int k = 0; k <= 8; k++) begin
            check($sformatf("p1_wb_en_k%0d", k), {25'd0, rec_wb[k]},
                  (k == 3 || k == 7) ? 32'h7F : 32'h0);
            check($sformatf("p1_busy_k%0d", k), {31'd0, rec_busy[k]}, 32'd1);
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("p1_which_k%0d", k), {30'd0, rec_wbi[k]}, (k < 4) ? 32'd0 : 32'd1);
        end
        check("p1_x_in_wr0", rec_xin[3], fx(125));
        check("p1_acc_in_wr0", rec_axin[3], 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("p1_pass_count", 32'(done_cnt - cnt0), 32'd1);
        check("p1_idle_busy", {31'd0, busy}, 32'd0);
        check("b0_x", mem_x[0], fx(125));
        check("b0_vx", mem_vx[0], fx(5));
        check("b0_y", mem_y[0], fx(100));
        check("b1_x_right_bounce", mem_x[1], fx(639));
        check("b1_vx_right_bounce", mem_vx[1], fx(-5));
        check("b1_y_exact_edge", mem_y[1], fx(479));
        check("b1_vy_exact_edge", mem_vy[1], fx(4));

        // Pass 2: velocity clamp, accumulator clear, left bounce, negative accel on y
        load_boid(1'b0, 10, 20, 5, 0, 3, 0);
        load_boid(1'b1, 2, 50, -4, 0, 0, -2);
        run_pass(1'b0, 99, dk);
        check("p2_done_latency", 32'(dk), 32'd8);
        check("b0_vx_clamped", mem_vx[0], fx(6));
        check("b0_x_clamped", mem_x[0], fx(16));
        check("b0_vxacc_cleared", mem_ax[0], 32'd0);
        check("b1_x_left_bounce", mem_x[1], fx(0));
        check("b1_vx_left_bounce", mem_vx[1], fx(4));
        check("b1_vy_from_acc", mem_vy[1], fx(-2));
        check("b1_y_from_acc", mem_y[1], fx(48));
        check("b1_vyacc_cleared", mem_ay[1], 32'd0);

        // Pass 3: reset during POS of boid 1 aborts with no write
        load_boid(1'b0, 100, 10, 1, 0, 0, 0);
        load_boid(1'b1, 200, 10, 3, 0, 0, 0);
        run_pass(1'b0, 6, dk);
        check("p3_abort_no_done", 32'(dk), 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        check("abort_wb_en", {25'd0, wb_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_which", {30'd0, which_boid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_b0_written", mem_x[0], fx(101));
        check("abort_b1_x_kept", mem_x[1], fx(200));
        check("abort_b1_vx_kept", mem_vx[1], fx(3));

        // Pass 4: full pass after abort
        run_pass(1'b0, 99, dk);
        check("p4_done_latency", 32'(dk), 32'd8);
        check("p4_b0_x", mem_x[0], fx(102));
        check("p4_b1_x", mem_x[1], fx(203));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
